priority_decoder: RTL and testbench



---
 rtl/priority_decoder.sv | 115 +++++++++++
 tb/tb_priority_decoder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/priority_decoder.sv
// Priority decoder: turns {code, V} words from the 8-to-3 priority encoder into one-hot words
// through a 2-entry valid/ready elastic buffer. Define DEC_NONE_STATS_EN to add the none_cnt port.
module priority_decoder #(
   parameter int unsigned CODE_W = 3,
   parameter int unsigned N_OUT  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CODE_W-1:0] in_code,
   input  logic              in_v,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [N_OUT-1:0]  out_onehot,
   output logic              out_none
`ifdef DEC_NONE_STATS_EN
   ,
   output logic [7:0]        none_cnt
`endif
);

   localparam int unsigned ENTRY_W = N_OUT + 1;

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   generate
      if (N_OUT != (2 ** CODE_W)) begin : g_bad_width
         $error("priority_decoder: N_OUT must equal 2**CODE_W");
      end
   endgenerate

   logic [1:0]         state_q;
   logic [1:0]         state_d;
   logic               head_q;
   logic               tail_q;
   logic [ENTRY_W-1:0] mem_q [2];
   logic [ENTRY_W-1:0] entry_c;
   logic [N_OUT-1:0]   dec_c;
   logic               push_c;
   logic               pop_c;

   // Decode by comparison so an unknown code with V=0 still yields an all-zero word.
   always_comb begin
      dec_c = '0;
      for (int unsigned i = 0; i < N_OUT; i++) begin
         if (in_v && (in_code == CODE_W'(i))) begin
            dec_c[i] = 1'b1;
         end
      end
      entry_c = {dec_c, ~in_v};
   end

   // Handshakes and outputs are decoded from occupancy only; no path from out_ready to in_ready.
   always_comb begin
      in_ready  = ~rst & (state_q != ST_FULL);
      out_valid = (state_q != ST_EMPTY);
      push_c    = in_valid & in_ready;
      pop_c     = out_valid & out_ready;
      {out_onehot, out_none} = '0;
      if (out_valid) begin
         {out_onehot, out_none} = mem_q[head_q];
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_EMPTY: begin
            if (push_c) state_d = ST_ONE;
         end
         ST_ONE: begin
            if (push_c && !pop_c)      state_d = ST_FULL;
            else if (pop_c && !push_c) state_d = ST_EMPTY;
         end
         ST_FULL: begin
            if (pop_c) state_d = ST_ONE;
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_EMPTY;
         head_q   <= 1'b0;
         tail_q   <= 1'b0;
         mem_q[0] <= '0;
         mem_q[1] <= '0;
      end else begin
         state_q <= state_d;
         if (push_c) begin
            mem_q[tail_q] <= entry_c;
            tail_q        <= ~tail_q;
         end
         if (pop_c) begin
            head_q <= ~head_q;
         end
      end
   end

`ifdef DEC_NONE_STATS_EN
   // Saturating count of accepted words that carried V=0; pops leave it alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         none_cnt <= 8'd0;
      end else if (push_c && !in_v && (none_cnt != 8'hFF)) begin
         none_cnt <= none_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_priority_decoder.sv
// Directed self-checking bench for priority_decoder (optionally with DEC_NONE_STATS_EN).
module tb_priority_decoder;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] in_code;
   logic       in_v;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_onehot;
   logic       out_none;
`ifdef DEC_NONE_STATS_EN
   logic [7:0] none_cnt;
   int         exp_none;
`endif

   int pass_cnt;
   int total_cnt;

   priority_decoder #(.CODE_W(3), .N_OUT(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_code    (in_code),
      .in_v       (in_v),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_onehot (out_onehot),
      .out_none   (out_none)
`ifdef DEC_NONE_STATS_EN
      ,
      .none_cnt   (none_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_code = 3'd0; in_v = 1'b0; out_ready = 1'b0;
      #1;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", in_ready); else pass_cnt++;
      total_cnt++; if ({out_onehot, out_none} !== 9'h000) $display("FAIL reset_data: got %h expected 000", {out_onehot, out_none}); else pass_cnt++;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b expected 1", in_ready); else pass_cnt++;
`ifdef DEC_NONE_STATS_EN
      exp_none = 0;
      total_cnt++; if (none_cnt !== 8'd0) $display("FAIL reset_none_cnt: got %0d expected 0", none_cnt); else pass_cnt++;
`endif
   endtask

   task automatic test_single();
      @(negedge clk);
      in_valid = 1'b1; in_code = 3'b101; in_v = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL single_valid: got %b expected 1", out_valid); else pass_cnt++;
      total_cnt++; if (out_onehot !== 8'b0010_0000) $display("FAIL single_onehot: got %h expected 20", out_onehot); else pass_cnt++;
      total_cnt++; if (out_none !== 1'b0) $display("FAIL single_none: got %b expected 0", out_none); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL single_drain: got %b expected 0", out_valid); else pass_cnt++;
      total_cnt++; if (out_onehot !== 8'h00) $display("FAIL single_drain_onehot: got %h expected 00", out_onehot); else pass_cnt++;
   endtask

   task automatic test_none();
      in_valid = 1'b1; in_code = 3'bxxx; in_v = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; in_code = 3'd0;
`ifdef DEC_NONE_STATS_EN
      exp_none = exp_none + 1;
      total_cnt++; if (none_cnt !== 8'(exp_none)) $display("FAIL none_cnt_inc: got %0d expected %0d", none_cnt, exp_none); else pass_cnt++;
`endif
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL none_valid: got %b expected 1", out_valid); else pass_cnt++;
      total_cnt++; if (out_onehot !== 8'h00) $display("FAIL none_onehot: got %h expected 00", out_onehot); else pass_cnt++;
      total_cnt++; if (out_none !== 1'b1) $display("FAIL none_flag: got %b expected 1", out_none); else pass_cnt++;
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      in_valid = 1'b1; in_code = 3'd7; in_v = 1'b1;
      @(negedge clk);
      in_code = 3'd0;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_ready_one: got %b expected 1", in_ready); else pass_cnt++;
      total_cnt++; if (out_onehot !== 8'h80) $display("FAIL bp_head_first: got %h expected 80", out_onehot); else pass_cnt++;
      @(negedge clk);
      in_code = 3'd3;
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_ready_full: got %b expected 0", in_ready); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (out_onehot !== 8'h80 || out_valid !== 1'b1) $display("FAIL bp_head_stable: got %b/%h expected 1/80", out_valid, out_onehot); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_ready_hold: got %b expected 0", in_ready); else pass_cnt++;
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      total_cnt++; if (out_onehot !== 8'h01 || out_valid !== 1'b1) $display("FAIL bp_second: got %b/%h expected 1/01", out_valid, out_onehot); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_ready_back: got %b expected 1", in_ready); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_third_dropped: got %b expected 0", out_valid); else pass_cnt++;
   endtask

   task automatic test_streaming();
      logic [7:0] exp_oh;
      out_ready = 1'b1;
      in_valid = 1'b1; in_v = 1'b1; in_code = 3'd0;
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         exp_oh = 8'd1 << i;
         total_cnt++; if (out_valid !== 1'b1 || out_onehot !== exp_oh) $display("FAIL stream_%0d: got %b/%h expected 1/%h", i, out_valid, out_onehot, exp_oh); else pass_cnt++;
         total_cnt++; if (in_ready !== 1'b1) $display("FAIL stream_ready_%0d: got %b expected 1", i, in_ready); else pass_cnt++;
         if (i < 7) in_code = 3'(i + 1);
         else in_valid = 1'b0;
         @(negedge clk);
      end
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL stream_drain: got %b expected 0", out_valid); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      in_valid = 1'b1; in_v = 1'b1; in_code = 3'd1;
      @(negedge clk);
      in_code = 3'd2;
      @(negedge clk);
      in_valid = 1'b0;
      total_cnt++; if (in_ready !== 1'b0 || out_valid !== 1'b1) $display("FAIL rmid_full: got %b/%b expected 0/1", in_ready, out_valid); else pass_cnt++;
      #2 rst = 1'b1;
      #1;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL rmid_valid: got %b expected 0", out_valid); else pass_cnt++;
      total_cnt++; if ({out_onehot, out_none} !== 9'h000) $display("FAIL rmid_data: got %h expected 000", {out_onehot, out_none}); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL rmid_ready: got %b expected 0", in_ready); else pass_cnt++;
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
`ifdef DEC_NONE_STATS_EN
      exp_none = 0;
`endif
      #1;
      total_cnt++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL rmid_release: got %b/%b expected 1/0", in_ready, out_valid); else pass_cnt++;
      repeat (3) @(negedge clk);
      total_cnt++; if (out_valid !== 1'b0 || out_onehot !== 8'h00) $display("FAIL rmid_no_old: got %b/%h expected 0/00", out_valid, out_onehot); else pass_cnt++;
   endtask

`ifdef DEC_NONE_STATS_EN
   task automatic test_saturation();
      out_ready = 1'b1;
      in_valid = 1'b1; in_v = 1'b0; in_code = 3'd0;
      repeat (300) @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      total_cnt++; if (none_cnt !== 8'd255) $display("FAIL sat_cnt: got %0d expected 255", none_cnt); else pass_cnt++;
      in_valid = 1'b1;
      repeat (4) @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      total_cnt++; if (none_cnt !== 8'd255) $display("FAIL sat_hold: got %0d expected 255", none_cnt); else pass_cnt++;
   endtask
`endif

   initial begin
      pass_cnt = 0;
      total_cnt = 0;
      test_reset();
      test_single();
      test_none();
      test_backpressure();
      test_streaming();
      test_reset_mid();
`ifdef DEC_NONE_STATS_EN
      test_saturation();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
